// File: rtl/pipe_hazard_sched_if.sv
// Hazard inputs from the datapath and per-stage stall/flush controls back to it.
interface pipe_hazard_sched_if;
    // hazard sources
    logic IFStallF;
    logic LoadUseHazE;
    logic BranchMispredE;
    logic MulDivStartE;
    logic DCacheStallM;
    logic TrapM;
    // pipeline register controls
    logic StallF;
    logic StallD;
    logic StallE;
    logic StallM;
    logic StallW;
    logic FlushD;
    logic FlushE;
    logic FlushM;
    logic FlushW;
    logic MulDivBusyE;
    logic StallTimeout;

    // datapath side: raises hazards, consumes controls
    modport master (
        output IFStallF, LoadUseHazE, BranchMispredE, MulDivStartE, DCacheStallM, TrapM,
        input  StallF, StallD, StallE, StallM, StallW,
        input  FlushD, FlushE, FlushM, FlushW,
        input  MulDivBusyE, StallTimeout
    );

    // hazard unit side
    modport slave (
        input  IFStallF, LoadUseHazE, BranchMispredE, MulDivStartE, DCacheStallM, TrapM,
        output StallF, StallD, StallE, StallM, StallW,
        output FlushD, FlushE, FlushM, FlushW,
        output MulDivBusyE, StallTimeout
    );
endinterface

// File: rtl/pipe_hazard_sched.sv
// Hazard/sequencing controller for a 5-stage pipeline: merges hazards into
// per-stage stall/flush, sequences mul/div occupancy of E, holds Fetch during
// a post-trap redirect window and flags runaway Fetch stalls.
module pipe_hazard_sched #(
    parameter int unsigned MULDIV_CYC = 32,
    parameter int unsigned REDIR_CYC  = 2,
    parameter int unsigned WDOG_MAX   = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    pipe_hazard_sched_if.slave   bus
);

    localparam int unsigned CNT_MAX = (MULDIV_CYC > REDIR_CYC) ? MULDIV_CYC : REDIR_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned WDOG_W  = $clog2(WDOG_MAX + 1);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_MULDIV = 2'd1;
    localparam logic [1:0] ST_TRAP   = 2'd2;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [WDOG_W-1:0] r_wdog;
    logic              r_timeout;

    logic [1:0]        w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_take_trap;
    logic              w_md_active;
    logic              w_md_hold;
    logic              w_busy;
    logic              w_stall_f, w_stall_d, w_stall_e, w_stall_m, w_stall_w;
    logic              w_flush_d, w_flush_e, w_flush_m, w_flush_w;

    // A trap waiting on the D$ is deferred until the cache releases M
    assign w_take_trap = bus.TrapM & ~bus.DCacheStallM;

    // Mul/div owns E on its start cycle and every cycle in MULDIV; E is held until the last one
    assign w_md_active = (r_state == ST_MULDIV) ||
                         ((r_state == ST_RUN) && bus.MulDivStartE);
    assign w_md_hold   = w_md_active && !((r_state == ST_MULDIV) && (r_cnt == '0));
    assign w_busy      = !reset && !w_take_trap && w_md_active;

    // Next-state and occupancy counter
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_take_trap) begin
            w_state_nxt = ST_TRAP;
            w_cnt_nxt   = CNT_W'(REDIR_CYC - 1);
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (bus.MulDivStartE) begin
                        w_state_nxt = ST_MULDIV;
                        w_cnt_nxt   = CNT_W'(MULDIV_CYC - 2);
                    end
                end
                ST_MULDIV: begin
                    if (!bus.DCacheStallM) begin
                        if (r_cnt == '0) begin
                            w_state_nxt = ST_RUN;
                        end else begin
                            w_cnt_nxt = r_cnt - CNT_W'(1);
                        end
                    end
                end
                ST_TRAP: begin
                    if (bus.TrapM) begin
                        w_cnt_nxt = CNT_W'(REDIR_CYC - 1);
                    end else if (r_cnt == '0) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Merge hazard requests into stall/flush: stalls propagate upstream, a stalled stage is never flushed
    always_comb begin
        w_stall_f = 1'b0;
        w_stall_d = 1'b0;
        w_stall_e = 1'b0;
        w_stall_m = 1'b0;
        w_stall_w = 1'b0;
        w_flush_d = 1'b0;
        w_flush_e = 1'b0;
        w_flush_m = 1'b0;
        w_flush_w = 1'b0;
        if (reset) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
            w_flush_m = 1'b1;
            w_flush_w = 1'b1;
        end else if (w_take_trap) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
            w_flush_m = 1'b1;
            w_flush_w = 1'b1;
        end else begin
            if (bus.DCacheStallM) begin
                w_stall_m = 1'b1;
                w_flush_w = 1'b1;
            end
            if (w_md_hold) begin
                w_stall_e = 1'b1;
                w_flush_m = 1'b1;
            end
            if (bus.LoadUseHazE) begin
                w_stall_d = 1'b1;
                w_flush_e = 1'b1;
            end
            if (bus.IFStallF || (r_state == ST_TRAP)) begin
                w_stall_f = 1'b1;
                w_flush_d = 1'b1;
            end
            w_stall_m = w_stall_m | w_stall_w;
            w_stall_e = w_stall_e | w_stall_m;
            w_stall_d = w_stall_d | w_stall_e;
            w_stall_f = w_stall_f | w_stall_d;
            if (bus.BranchMispredE && !w_stall_e) begin
                w_flush_d = 1'b1;
                w_flush_e = 1'b1;
            end
            w_flush_d = w_flush_d & ~w_stall_d;
            w_flush_e = w_flush_e & ~w_stall_e;
            w_flush_m = w_flush_m & ~w_stall_m;
            w_flush_w = w_flush_w & ~w_stall_w;
        end
    end

    // Sequencer state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Consecutive Fetch-stall watchdog with sticky timeout flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (!w_stall_f) begin
                r_wdog <= '0;
            end else if (r_wdog != WDOG_W'(WDOG_MAX)) begin
                r_wdog <= r_wdog + WDOG_W'(1);
            end
            if (w_stall_f && (r_wdog == WDOG_W'(WDOG_MAX - 1))) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign bus.StallF       = w_stall_f;
    assign bus.StallD       = w_stall_d;
    assign bus.StallE       = w_stall_e;
    assign bus.StallM       = w_stall_m;
    assign bus.StallW       = w_stall_w;
    assign bus.FlushD       = w_flush_d;
    assign bus.FlushE       = w_flush_e;
    assign bus.FlushM       = w_flush_m;
    assign bus.FlushW       = w_flush_w;
    assign bus.MulDivBusyE  = w_busy;
    assign bus.StallTimeout = r_timeout;

endmodule

// File: tb/tb_pipe_hazard_sched.sv
// Directed bench for pipe_hazard_sched: expected control vectors are queued
// when each stimulus is applied and checked once the outputs settle.
module tb_pipe_hazard_sched;

    // stimulus bits {IFStallF, LoadUseHazE, BranchMispredE, MulDivStartE, DCacheStallM, TrapM}
    localparam logic [5:0] I_NONE = 6'b000000;
    localparam logic [5:0] I_IF   = 6'b100000;
    localparam logic [5:0] I_LU   = 6'b010000;
    localparam logic [5:0] I_BM   = 6'b001000;
    localparam logic [5:0] I_MD   = 6'b000100;
    localparam logic [5:0] I_DC   = 6'b000010;
    localparam logic [5:0] I_TR   = 6'b000001;

    // expected {StallF,D,E,M,W, FlushD,E,M,W, MulDivBusyE, StallTimeout}
    localparam logic [10:0] E_IDLE  = 11'b00000_0000_0_0;
    localparam logic [10:0] E_RST   = 11'b00000_1111_0_0;
    localparam logic [10:0] E_TRAP  = 11'b00000_1111_0_0;
    localparam logic [10:0] E_MD    = 11'b11100_0010_1_0;
    localparam logic [10:0] E_MDL   = 11'b00000_0000_1_0;
    localparam logic [10:0] E_REDIR = 11'b10000_1000_0_0;
    localparam logic [10:0] E_DC    = 11'b11110_0001_0_0;
    localparam logic [10:0] E_DCMD  = 11'b11110_0001_1_0;
    localparam logic [10:0] E_LU    = 11'b11000_0100_0_0;
    localparam logic [10:0] E_BM    = 11'b00000_1100_0_0;
    localparam logic [10:0] E_IF    = 11'b10000_1000_0_0;
    localparam logic [10:0] E_TO    = 11'b00000_0000_0_1;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [10:0] sb_q[$];

    pipe_hazard_sched_if hz ();

    pipe_hazard_sched #(
        .MULDIV_CYC (4),
        .REDIR_CYC  (2),
        .WDOG_MAX   (255)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pop the oldest expectation and compare against the settled outputs
    task automatic compare(input string tag);
        logic [10:0] got;
        logic [10:0] exp;
        got = {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.StallW,
               hz.FlushD, hz.FlushE, hz.FlushM, hz.FlushW,
               hz.MulDivBusyE, hz.StallTimeout};
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty got=%b", tag, got);
        end else begin
            exp = sb_q.pop_front();
            assert (got === exp) else begin
                errors++;
                $error("FAIL %s got=%b exp=%b", tag, got, exp);
            end
        end
    endtask

    // apply one cycle of stimulus after the falling edge and check before the rising edge
    task automatic step(input logic [5:0] stim, input logic [10:0] exp, input string tag);
        @(negedge clk);
        {hz.IFStallF, hz.LoadUseHazE, hz.BranchMispredE,
         hz.MulDivStartE, hz.DCacheStallM, hz.TrapM} = stim;
        sb_q.push_back(exp);
        #2;
        compare(tag);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        {hz.IFStallF, hz.LoadUseHazE, hz.BranchMispredE,
         hz.MulDivStartE, hz.DCacheStallM, hz.TrapM} = I_NONE;
        #2;
        sb_q.push_back(E_RST);
        compare("reset_state");
        @(negedge clk);
        reset = 1'b0;
        step(I_NONE, E_IDLE, "idle");

        // mul/div occupancy, 4 cycles
        step(I_MD,   E_MD,   "md_c1");
        step(I_NONE, E_MD,   "md_c2");
        step(I_NONE, E_MD,   "md_c3");
        step(I_NONE, E_MDL,  "md_c4_release");
        step(I_NONE, E_IDLE, "md_back_run");

        // trap aborts mul/div, then two redirect cycles
        step(I_MD,   E_MD,    "mdtrap_c1");
        step(I_TR,   E_TRAP,  "mdtrap_take");
        step(I_NONE, E_REDIR, "mdtrap_redir1");
        step(I_NONE, E_REDIR, "mdtrap_redir2");
        step(I_NONE, E_IDLE,  "mdtrap_run");

        // trap deferred behind D$ stall
        step(I_TR | I_DC, E_DC,    "trapdc_1");
        step(I_TR | I_DC, E_DC,    "trapdc_2");
        step(I_TR | I_DC, E_DC,    "trapdc_3");
        step(I_TR,        E_TRAP,  "trapdc_take");
        step(I_NONE,      E_REDIR, "trapdc_redir1");
        step(I_NONE,      E_REDIR, "trapdc_redir2");
        step(I_NONE,      E_IDLE,  "trapdc_run");

        // merged single-cycle hazards
        step(I_LU | I_BM, E_LU,   "lu_bm_mask");
        step(I_LU,        E_LU,   "lu_only");
        step(I_BM,        E_BM,   "bm_only");
        step(I_IF,        E_IF,   "if_only");
        step(I_IF | I_LU, E_LU,   "if_lu_mask");
        step(I_DC | I_BM, E_DC,   "dc_bm_mask");
        step(I_NONE,      E_IDLE, "merge_idle");

        // D$ stall freezes the mul/div counter
        step(I_MD,   E_MD,   "mddc_c1");
        step(I_DC,   E_DCMD, "mddc_frozen");
        step(I_NONE, E_MD,   "mddc_c2");
        step(I_NONE, E_MD,   "mddc_c3");
        step(I_NONE, E_MDL,  "mddc_release");
        step(I_NONE, E_IDLE, "mddc_run");

        // watchdog: flag after 255 consecutive Fetch stalls, sticky afterwards
        for (int i = 0; i < 255; i++) begin
            step(I_IF, E_IF, "wdog_pre");
        end
        step(I_IF,   E_IF | E_TO, "wdog_hit");
        step(I_IF,   E_IF | E_TO, "wdog_sat");
        step(I_NONE, E_TO,        "wdog_sticky");

        // async reset in the middle of mul/div
        step(I_MD,   E_MD | E_TO, "rstmd_c1");
        step(I_NONE, E_MD | E_TO, "rstmd_c2");
        #1;
        reset = 1'b1;
        #1;
        sb_q.push_back(E_RST);
        compare("rstmd_async");
        @(negedge clk);
        reset = 1'b0;
        step(I_NONE, E_IDLE, "rstmd_run");
        step(I_MD,   E_MD,   "rstmd_md_c1");
        step(I_NONE, E_MD,   "rstmd_md_c2");
        step(I_NONE, E_MD,   "rstmd_md_c3");
        step(I_NONE, E_MDL,  "rstmd_md_c4");
        step(I_NONE, E_IDLE, "rstmd_md_done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
